// File: rtl/cobs_packet_encoder_if.sv
// Sample-in / packet-out bundle for cobs_packet_encoder.
// slave: encoder side, master: sample source and packet reader.
interface cobs_packet_encoder_if #(
  parameter int SAMPLE_BYTES = 3,
  parameter int ADDR_WIDTH   = 8
) ();
  logic                      i_we;
  logic [8*SAMPLE_BYTES-1:0] i_wdata;
  logic                      o_ready;
  logic                      o_stb;
  logic [ADDR_WIDTH-1:0]     o_plen;
  logic                      i_rack;
  logic [ADDR_WIDTH-1:0]     i_raddr;
  logic [7:0]                o_rdata;
  logic                      o_overflow;

  modport master (
    output i_we, i_wdata, i_rack, i_raddr,
    input  o_ready, o_stb, o_plen, o_rdata, o_overflow
  );

  modport slave (
    input  i_we, i_wdata, i_rack, i_raddr,
    output o_ready, o_stb, o_plen, o_rdata, o_overflow
  );
endinterface

// File: rtl/cobs_packet_encoder.sv
// Double-buffered constant-length COBS packet encoder.
// Define COBS_ENC_DELIM_EN to append a 0x00 delimiter byte.
module cobs_packet_encoder #(
  parameter int SAMPLE_BYTES = 3,
  parameter int PAYLOAD_LEN  = 252,
  parameter int ADDR_WIDTH   = 8
) (
  input logic i_clk,
  input logic i_rst_n,
  cobs_packet_encoder_if.slave bus
);
  localparam int SW    = 8 * SAMPLE_BYTES;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(PAYLOAD_LEN);
`ifdef COBS_ENC_DELIM_EN
  localparam logic [ADDR_WIDTH-1:0] PLEN =
    ADDR_WIDTH'(PAYLOAD_LEN + 2);
`else
  localparam logic [ADDR_WIDTH-1:0] PLEN =
    ADDR_WIDTH'(PAYLOAD_LEN + 1);
`endif
  localparam logic [7:0] BCNT_INIT = 8'(SAMPLE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_BYTE, S_FINAL, S_DELIM, S_HOLD
  } state_t;

  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] p_idx, p_n;
  logic [ADDR_WIDTH-1:0] z_idx, z_n;
  logic [SW-1:0] sh, sh_n;
  logic [7:0] bcnt, bcnt_n;
  logic wsel, wsel_n;
  logic pend, pend_n;
  logic stb, stb_n;
  logic ovf, ovf_n;
  logic ready;

  logic enc, last, swap;
  logic [7:0] cur;

  logic we_n;
  logic [ADDR_WIDTH-1:0] wa_n;
  logic [7:0] wd_n;

  logic wr_en, wr_bank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0] wr_data;

  logic [7:0] mem0 [DEPTH];
  logic [7:0] mem1 [DEPTH];
  logic [7:0] rdata;
  logic rbank;

  assign ready = (state == S_IDLE);
  assign rbank = ~wsel;

  // Next state, byte encoder and write request.
  always_comb begin
    state_n = state;
    p_n     = p_idx;
    z_n     = z_idx;
    sh_n    = sh;
    bcnt_n  = bcnt;
    wsel_n  = wsel;
    pend_n  = pend;
    stb_n   = 1'b0;
    ovf_n   = ovf | (bus.i_we & ~ready);
    enc     = 1'b0;
    last    = 1'b0;
    swap    = 1'b0;
    cur     = sh[SW-1 -: 8];
    we_n    = 1'b0;
    wa_n    = z_idx;
    wd_n    = 8'hFF;
    if (bus.i_rack && pend) pend_n = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.i_we) begin
          enc     = 1'b1;
          cur     = bus.i_wdata[SW-1 -: 8];
          sh_n    = bus.i_wdata << 8;
          bcnt_n  = BCNT_INIT;
          last    = (SAMPLE_BYTES == 1);
          state_n = S_BYTE;
        end
      end
      S_BYTE: begin
        enc    = 1'b1;
        sh_n   = sh << 8;
        bcnt_n = bcnt - 8'd1;
        last   = (bcnt == 8'd1);
      end
      S_FINAL: begin
        we_n = 1'b1;
        wa_n = z_idx;
        wd_n = 8'hFF;
`ifdef COBS_ENC_DELIM_EN
        state_n = S_DELIM;
`else
        swap    = ~pend | bus.i_rack;
        state_n = swap ? S_IDLE : S_HOLD;
`endif
      end
`ifdef COBS_ENC_DELIM_EN
      S_DELIM: begin
        we_n    = 1'b1;
        wa_n    = PLEN - ONE;
        wd_n    = 8'h00;
        swap    = ~pend | bus.i_rack;
        state_n = swap ? S_IDLE : S_HOLD;
      end
`endif
      S_HOLD: begin
        swap    = bus.i_rack;
        state_n = swap ? S_IDLE : S_HOLD;
      end
      default: state_n = S_IDLE;
    endcase
    if (enc) begin
      we_n = 1'b1;
      p_n  = p_idx + ONE;
      if (cur != 8'h00) begin
        wa_n = p_idx;
        wd_n = cur;
      end else begin
        wa_n = z_idx;
        wd_n = 8'(p_idx);
        z_n  = p_idx;
      end
      if (last)
        state_n = (p_idx == LAST_IDX) ? S_FINAL : S_IDLE;
    end
    if (swap) begin
      wsel_n = ~wsel;
      pend_n = 1'b1;
      stb_n  = 1'b1;
      p_n    = ONE;
      z_n    = '0;
    end
  end

  // Control state and registered write port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      p_idx   <= ONE;
      z_idx   <= '0;
      sh      <= '0;
      bcnt    <= '0;
      wsel    <= 1'b0;
      pend    <= 1'b0;
      stb     <= 1'b0;
      ovf     <= 1'b0;
      wr_en   <= 1'b0;
      wr_bank <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      p_idx   <= p_n;
      z_idx   <= z_n;
      sh      <= sh_n;
      bcnt    <= bcnt_n;
      wsel    <= wsel_n;
      pend    <= pend_n;
      stb     <= stb_n;
      ovf     <= ovf_n;
      wr_en   <= we_n;
      wr_bank <= wsel;
      wr_addr <= wa_n;
      wr_data <= wd_n;
    end
  end

  // Commit the write into the bank it was encoded for.
  always_ff @(posedge i_clk) begin
    if (wr_en && !wr_bank) mem0[wr_addr] <= wr_data;
    if (wr_en &&  wr_bank) mem1[wr_addr] <= wr_data;
  end

  // Read port; the last write of a packet lands just after
  // the swap, so forward it to the reader.
  always_ff @(posedge i_clk) begin
    if (wr_en && wr_bank == rbank && wr_addr == bus.i_raddr)
      rdata <= wr_data;
    else
      rdata <= rbank ? mem1[bus.i_raddr] : mem0[bus.i_raddr];
  end

  assign bus.o_ready    = ready;
  assign bus.o_stb      = stb;
  assign bus.o_plen     = PLEN;
  assign bus.o_overflow = ovf;
  assign bus.o_rdata    = rdata;
endmodule

// File: tb/tb_cobs_packet_encoder.sv
// Scoreboard bench for cobs_packet_encoder: a default-size
// instance and a 2-byte/16-byte instance.
`timescale 1ns/1ps
module tb_cobs_packet_encoder;
`ifdef COBS_ENC_DELIM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int PLEN_A = 253 + EXTRA;
  localparam int PLEN_B = 17 + EXTRA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cobs_packet_encoder_if #(.SAMPLE_BYTES(3), .ADDR_WIDTH(8)) bus_a ();
  cobs_packet_encoder_if #(.SAMPLE_BYTES(2), .ADDR_WIDTH(5)) bus_b ();

  cobs_packet_encoder #(
    .SAMPLE_BYTES(3), .PAYLOAD_LEN(252), .ADDR_WIDTH(8)
  ) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));

  cobs_packet_encoder #(
    .SAMPLE_BYTES(2), .PAYLOAD_LEN(16), .ADDR_WIDTH(5)
  ) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  int n_chk = 0;
  int n_fail = 0;
  int stb_a = 0;
  int stb_b = 0;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  logic rdv_a = 1'b0, rdv_b = 1'b0;
  logic rv_a = 1'b0, rv_b = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    rv_a <= rdv_a;
    rv_b <= rdv_b;
  end

  always @(negedge clk) begin
    if (bus_a.o_stb) stb_a++;
    if (bus_b.o_stb) stb_b++;
  end

  // Monitor: each read issued returns data one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (rv_a) begin
      if (q_a.size() == 0) check("rd_a_queue_empty", 1, 0);
      else begin
        e = q_a.pop_front();
        check(e.name, bus_a.o_rdata, e.val);
      end
    end
    if (rv_b) begin
      if (q_b.size() == 0) check("rd_b_queue_empty", 1, 0);
      else begin
        e = q_b.pop_front();
        check(e.name, bus_b.o_rdata, e.val);
      end
    end
  end

  function automatic logic [7:0] pat(input int i, input logic [23:0] s);
    int sel;
    sel = (i - 1) % 3;
    return s[23 - 8*sel -: 8];
  endfunction

  task automatic send_a(input logic [23:0] s);
    int n = 0;
    while (!bus_a.o_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.o_ready) check("send_a_ready_timeout", 0, 1);
    else begin
      bus_a.i_we = 1'b1;
      bus_a.i_wdata = s;
      @(negedge clk);
      bus_a.i_we = 1'b0;
    end
  endtask

  task automatic send_b(input logic [15:0] s);
    int n = 0;
    while (!bus_b.o_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus_b.o_ready) check("send_b_ready_timeout", 0, 1);
    else begin
      bus_b.i_we = 1'b1;
      bus_b.i_wdata = s;
      @(negedge clk);
      bus_b.i_we = 1'b0;
    end
  endtask

  task automatic wait_stb_a(input int lat, input string nm);
    int n = 1;
    while (!bus_a.o_stb && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, n, lat);
    @(negedge clk);
  endtask

  task automatic read_a(input int addr, input logic [7:0] v,
                        input string nm);
    exp_t e;
    e.name = $sformatf("%s[%0d]", nm, addr);
    e.val = v;
    q_a.push_back(e);
    bus_a.i_raddr = 8'(addr);
    rdv_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_b(input int addr, input logic [7:0] v,
                        input string nm);
    exp_t e;
    e.name = $sformatf("%s[%0d]", nm, addr);
    e.val = v;
    q_b.push_back(e);
    bus_b.i_raddr = 5'(addr);
    rdv_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    rdv_a = 1'b0;
    rdv_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Whole packet of a sample pattern; head given separately.
  task automatic read_pkt_a(input logic [23:0] s, input string nm);
    for (int i = 0; i < PLEN_A; i++) begin
      if (i == 0) read_a(i, 8'hFF, nm);
      else if (i <= 252) read_a(i, pat(i, s), nm);
      else read_a(i, 8'h00, nm);
    end
    drain();
  endtask

  task automatic ack_a();
    bus_a.i_rack = 1'b1;
    @(negedge clk);
    bus_a.i_rack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    bus_a.i_we = 1'b0;
    bus_a.i_wdata = '0;
    bus_a.i_rack = 1'b0;
    bus_a.i_raddr = '0;
    bus_b.i_we = 1'b0;
    bus_b.i_wdata = '0;
    bus_b.i_rack = 1'b0;
    bus_b.i_raddr = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus_a.o_ready, 1);
    check("rst_stb", bus_a.o_stb, 0);
    check("rst_overflow", bus_a.o_overflow, 0);
    check("plen_a", bus_a.o_plen, PLEN_A);
    check("plen_b", bus_b.o_plen, PLEN_B);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-free packet.
    for (int k = 0; k < 84; k++) send_a(24'h010203);
    wait_stb_a(4 + EXTRA, "t1_stb_latency");
    read_pkt_a(24'h010203, "t1_buf");
    ack_a();
    check("t1_stb_count", stb_a, 1);
    check("t1_overflow", bus_a.o_overflow, 0);

    // Leading zero sample builds a code chain.
    send_a(24'h000000);
    for (int k = 0; k < 83; k++) send_a(24'h0A0B0C);
    wait_stb_a(4 + EXTRA, "t2_stb_latency");
    read_a(0, 8'd1, "t2_buf");
    read_a(1, 8'd2, "t2_buf");
    read_a(2, 8'd3, "t2_buf");
    read_a(3, 8'hFF, "t2_buf");
    for (int i = 4; i <= 252; i++)
      read_a(i, pat(i, 24'h0A0B0C), "t2_buf");
    if (EXTRA == 1) read_a(253, 8'h00, "t2_buf");
    drain();
    ack_a();

    // Two packets, reader silent: second one holds.
    for (int k = 0; k < 84; k++) send_a(24'h111111);
    wait_stb_a(4 + EXTRA, "t3_stb_first");
    for (int k = 0; k < 84; k++) send_a(24'h222222);
    s0 = stb_a;
    repeat (6) @(negedge clk);
    check("t3_hold_ready", bus_a.o_ready, 0);
    check("t3_hold_no_stb", stb_a, s0);
    read_a(1, 8'h11, "t3_old_pkt");
    read_a(0, 8'hFF, "t3_old_pkt");
    drain();
    check("t3_overflow_before", bus_a.o_overflow, 0);
    bus_a.i_we = 1'b1;
    bus_a.i_wdata = 24'h999999;
    @(negedge clk);
    bus_a.i_we = 1'b0;
    check("t3_overflow_set", bus_a.o_overflow, 1);
    bus_a.i_rack = 1'b1;
    @(negedge clk);
    bus_a.i_rack = 1'b0;
    check("t3_stb_after_rack", bus_a.o_stb, 1);
    @(negedge clk);
    read_pkt_a(24'h222222, "t3_buf");
    ack_a();
    check("t3_overflow_sticky", bus_a.o_overflow, 1);

    // Reset mid-packet.
    for (int k = 0; k < 40; k++) send_a(24'h333333);
    s0 = stb_a;
    rst_n = 1'b0;
    #1;
    check("t4_rst_ready", bus_a.o_ready, 1);
    check("t4_rst_stb", bus_a.o_stb, 0);
    check("t4_rst_overflow", bus_a.o_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_no_stb", stb_a, s0);
    for (int k = 0; k < 84; k++) send_a(24'h445566);
    wait_stb_a(4 + EXTRA, "t4_stb_latency");
    read_pkt_a(24'h445566, "t4_buf");
    ack_a();
    check("t4_stb_count", stb_a, s0 + 1);

    // Small instance, alternating zero bytes.
    for (int k = 0; k < 8; k++) send_b(16'h0100);
    begin
      int n = 1;
      while (!bus_b.o_stb && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("t5_stb_latency", n, 3 + EXTRA);
      @(negedge clk);
    end
    for (int i = 0; i < PLEN_B; i++) begin
      if (i == 16) read_b(i, 8'hFF, "t5_buf");
      else if (i == 17) read_b(i, 8'h00, "t5_buf");
      else if (i % 2 == 0) read_b(i, 8'(i + 2), "t5_buf");
      else read_b(i, 8'h01, "t5_buf");
    end
    drain();
    check("t5_stb_count", stb_b, 1);
    check("t5_overflow", bus_b.o_overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
